// File: rtl/microp_pkg.sv
// Shared definitions for the fetch front end and the control unit.
//   ADDR_W / INSTR_W : PC and instruction widths
//   RESET_PC         : PC value loaded at reset
//   OP_*             : 2-bit opcode encodings carried in instr[INSTR_W-1 -: 2]
//   fetch_entry_t    : one queued instruction together with its fetch address
package microp_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned OCC_W   = 2;
  localparam int unsigned OP_W    = 2;

  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_LW  = 2'b01;
  localparam logic [OP_W-1:0] OP_SW  = 2'b10;
  localparam logic [OP_W-1:0] OP_J   = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Opcode field of an instruction word.
  function automatic logic [OP_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Two-entry instruction queue of {pc, instr}; entry 0 is always the head.
//   push/push_pc/push_instr : enqueue at end of cycle
//   pop                     : head consumed at end of cycle
//   flush                   : empty the queue at end of cycle (overrides push/pop)
//   occ                     : current occupancy 0..2
//   head_pc/head_instr      : contents of entry 0
module instr_fifo
  import microp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [OCC_W-1:0]   occ,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  logic [OCC_W-1:0] occ_q, occ_d;
  fetch_entry_t     e0_q, e0_d;
  fetch_entry_t     e1_q, e1_d;
  fetch_entry_t     push_entry;

  // Next-state for occupancy and the two shift slots.
  always_comb begin
    occ_d      = occ_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    push_entry = '{pc: push_pc, instr: push_instr};
    if (flush) begin
      occ_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) e0_d = push_entry;
          else               e1_d = push_entry;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (occ_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = push_entry;
          end else begin
            e0_d = push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign occ        = occ_q;
  assign head_pc    = e0_q.pc;
  assign head_instr = e0_q.instr;

  // The issue rule in the parent never lets a response land in a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && occ_q == 2'd2));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, synchronous imem read issue, 2-entry
// instruction queue and redirect handling toward the control decoder.
//   fetch_en                     : allow new memory requests
//   imem_req/imem_addr           : read strobe and address (combinational)
//   imem_rdata                   : read data, one cycle after imem_req
//   instr_valid/instr_ready      : head handshake toward the decoder
//   instr/instr_pc/opcode        : head instruction, its address, its opcode
//   redirect_valid/redirect_pc   : taken jump/branch from execute
module instr_fetch
  import microp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [OP_W-1:0]    opcode,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic               drop_q, drop_d;

  logic [OCC_W-1:0]   occ;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               pop;
  logic               push;
  logic [2:0]         pending;

  assign instr_valid = (occ != '0);
  assign pop         = instr_valid & instr_ready;

  // Slots already claimed after this cycle's pop; pop never exceeds occ.
  assign pending = 3'(occ) + 3'(inflight_q) - 3'(pop);

  // Same-cycle pop frees a slot, hence the intended path instr_ready -> imem_req.
  assign imem_req  = rst_n & fetch_en & ~redirect_valid & (pending < 3'd2);
  assign imem_addr = pc_q;

  // A response is kept unless it belongs to a path abandoned by a redirect.
  assign push = inflight_q & ~drop_q & ~redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    drop_d     = redirect_valid & inflight_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (imem_req) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  instr_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (req_pc_q),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (redirect_valid),
    .occ        (occ),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  assign instr    = head_instr;
  assign instr_pc = head_pc;
  assign opcode   = get_opcode(head_instr);

endmodule
